// File: rtl/program_checker_pkg.sv
// Shared types for the program checker: FSM states, verdict codes and the
// expected-store table entry.
package checker_pkg;

  localparam int CHK_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STAT_NONE     = 2'd0,
    STAT_PASS     = 2'd1,
    STAT_MISMATCH = 2'd2,
    STAT_TIMEOUT  = 2'd3
  } status_e;

  typedef struct packed {
    logic [CHK_XLEN-1:0] addr;
    logic [CHK_XLEN-1:0] data;
  } exp_entry_t;

  // Configuration and start are only honoured while the checker is quiescent.
  function automatic logic is_quiescent(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/program_checker_reg_dump_seq.sv
// Register-file snapshot sequencer: walks the debug read address from 0 to
// NUM_REGS-1 while enabled and streams each read value one cycle later.
module reg_dump_seq #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [REG_AW-1:0] i_debug_addr,
  input  logic [XLEN-1:0]   o_debug_data,
  output logic              dump_valid,
  output logic [REG_AW-1:0] dump_idx,
  output logic [XLEN-1:0]   dump_data,
  output logic              seq_done
);

  localparam logic [REG_AW-1:0] LAST = REG_AW'(NUM_REGS - 1);

  logic              issue;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic              fin_q, fin_d;
  logic              vld_q, vld_d;
  logic [REG_AW-1:0] idx_q, idx_d;
  logic [XLEN-1:0]   data_q, data_d;

  // Advance the read pointer once per enabled cycle until the last register is issued.
  always_comb begin
    issue  = en && !fin_q;
    ptr_d  = ptr_q;
    fin_d  = fin_q;
    if (!en) begin
      ptr_d = '0;
      fin_d = 1'b0;
    end else if (issue) begin
      if (ptr_q == LAST) begin
        ptr_d = '0;
        fin_d = 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
    vld_d  = issue;
    idx_d  = issue ? ptr_q : '0;
    data_d = issue ? o_debug_data : '0;
  end

  // Pointer state and the registered capture of the combinational read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      fin_q  <= 1'b0;
      vld_q  <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      fin_q  <= fin_d;
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  assign i_debug_addr = issue ? ptr_q : '0;
  assign dump_valid   = vld_q;
  assign dump_idx     = idx_q;
  assign dump_data    = data_q;
  // High during the final beat so the owner can leave its dump state next edge.
  assign seq_done     = vld_q && (idx_q == LAST);

endmodule

// File: rtl/program_checker.sv
// Self-checking monitor for the single-cycle core: matches data-memory stores
// against an ordered expected list, enforces a run timeout, then streams a
// register-file snapshot through the debug port.
module program_checker
  import checker_pkg::*;
#(
  parameter int XLEN       = CHK_XLEN,
  parameter int NUM_CHECKS = 4,
  parameter int TIMEOUT    = 1024,
  parameter int NUM_REGS   = 32,
  localparam int REG_AW    = $clog2(NUM_REGS),
  localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CNT_W     = $clog2(NUM_CHECKS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [XLEN-1:0]   cfg_addr,
  input  logic [XLEN-1:0]   cfg_data,
  input  logic [CNT_W-1:0]  num_checks,
  input  logic              MemWrite,
  input  logic [XLEN-1:0]   DataAddr,
  input  logic [XLEN-1:0]   WriteData,
  output logic [REG_AW-1:0] i_debug_addr,
  input  logic [XLEN-1:0]   o_debug_data,
  output logic              dump_valid,
  output logic [REG_AW-1:0] dump_idx,
  output logic [XLEN-1:0]   dump_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [31:0]       cycle_count,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [XLEN-1:0]   fail_data
);

  state_e            state_q, state_d;
  status_e           status_q, status_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]  fail_idx_q, fail_idx_d;
  logic [XLEN-1:0]   fail_data_q, fail_data_d;
  exp_entry_t        table_q [NUM_CHECKS];
  exp_entry_t        table_d [NUM_CHECKS];

  exp_entry_t        cur_entry;
  logic [31:0]       cnt_inc;
  logic              decided;
  logic              seq_done;

  // Next-state, table programming and store matching.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    k_d         = k_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    fail_idx_d  = fail_idx_q;
    fail_data_d = fail_data_q;
    table_d     = table_q;
    decided     = 1'b0;
    cur_entry   = table_q[k_q[IDX_W-1:0]];
    cnt_inc     = cnt_q + 32'd1;

    if (is_quiescent(state_q)) begin
      if (cfg_we && (int'(cfg_idx) < NUM_CHECKS)) begin
        table_d[cfg_idx] = '{addr: cfg_addr, data: cfg_data};
      end
      if (start) begin
        state_d     = ST_RUN;
        status_d    = STAT_NONE;
        k_d         = '0;
        num_d       = num_checks;
        cnt_d       = '0;
        fail_idx_d  = '0;
        fail_data_d = '0;
      end
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_inc;
      if (num_q == '0) begin
        decided  = 1'b1;
        status_d = STAT_PASS;
      end else if (MemWrite && (DataAddr == cur_entry.addr)) begin
        if (WriteData == cur_entry.data) begin
          k_d = k_q + 1'b1;
          if (k_q == num_q - CNT_W'(1)) begin
            decided  = 1'b1;
            status_d = STAT_PASS;
          end
        end else begin
          decided     = 1'b1;
          status_d    = STAT_MISMATCH;
          fail_idx_d  = k_q[IDX_W-1:0];
          fail_data_d = WriteData;
        end
      end
      // A verdict on the timeout edge wins over the timeout itself.
      if (!decided && (cnt_inc == 32'(TIMEOUT))) begin
        decided  = 1'b1;
        status_d = STAT_TIMEOUT;
      end
      if (decided) begin
        state_d = ST_DUMP;
      end
    end else if (state_q == ST_DUMP) begin
      if (seq_done) begin
        state_d = ST_DONE;
      end
    end
  end

  // Checker state; reset also clears the expected table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      status_q    <= STAT_NONE;
      k_q         <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      fail_idx_q  <= '0;
      fail_data_q <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      k_q         <= k_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      fail_idx_q  <= fail_idx_d;
      fail_data_q <= fail_data_d;
      table_q     <= table_d;
    end
  end

  reg_dump_seq #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_dump (
    .clk          (clk),
    .rst          (rst),
    .en           (state_q == ST_DUMP),
    .i_debug_addr (i_debug_addr),
    .o_debug_data (o_debug_data),
    .dump_valid   (dump_valid),
    .dump_idx     (dump_idx),
    .dump_data    (dump_data),
    .seq_done     (seq_done)
  );

  assign busy        = (state_q == ST_RUN) || (state_q == ST_DUMP);
  assign done        = (state_q == ST_DONE);
  assign status      = status_q;
  assign cycle_count = cnt_q;
  assign fail_idx    = fail_idx_q;
  assign fail_data   = fail_data_q;

endmodule
